// File: rtl/ha_array_accumulator.sv
// Final-summation stage for the 8x8 approximate multiplier: folds the four
// half-adder-array rows, weighted by 4^k, into a 17-bit accumulator.
module ha_array_accumulator #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [6:0]  ha_array_1_b,
    input  logic [8:0]  ha_array_1_t,
    input  logic [6:0]  ha_array_2_b,
    input  logic [8:0]  ha_array_2_t,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        overflow
);

    localparam int R = ROWS_PER_CYCLE;

    generate
        if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rows_per_cycle
            $error("ha_array_accumulator: ROWS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [1:0]  idx_reg;
    logic [16:0] acc_reg, acc_next;
    logic [15:0] product_reg;
    logic        overflow_reg;
    logic [6:0]  b_in [4];
    logic [8:0]  t_in [4];
    logic [6:0]  b_reg [4];
    logic [8:0]  t_reg [4];
    logic [16:0] row_shift [4];
    logic [16:0] term [R];
    logic [2:0]  idx_end;
    logic        last_step;
    logic        accept;

    assign b_in[0] = ha_array_0_b;
    assign b_in[1] = ha_array_1_b;
    assign b_in[2] = ha_array_2_b;
    assign b_in[3] = ha_array_3_b;
    assign t_in[0] = ha_array_0_t;
    assign t_in[1] = ha_array_1_t;
    assign t_in[2] = ha_array_2_t;
    assign t_in[3] = ha_array_3_t;

    // Row value t + 4b fits in 10 bits; row k is then weighted by 4^k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            logic [9:0] row_val;
            assign row_val       = {1'b0, t_reg[gi]} + {1'b0, b_reg[gi], 2'b00};
            assign row_shift[gi] = {7'b0, row_val} << (2 * gi);
        end
        // idx_reg is always a multiple of R, so idx+gi never wraps past row 3.
        for (gi = 0; gi < R; gi++) begin : g_term
            assign term[gi] = row_shift[idx_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < R; i++) begin
            acc_next = acc_next + term[i];
        end
    end

    assign idx_end   = {1'b0, idx_reg} + 3'(R);
    assign last_step = (idx_end == 3'd4);
    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign product   = product_reg;
    assign overflow  = overflow_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCUM;
            ACCUM:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = in_valid ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            acc_reg      <= '0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                b_reg[i] <= '0;
                t_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (accept) begin
                acc_reg <= '0;
                idx_reg <= '0;
                for (int i = 0; i < 4; i++) begin
                    b_reg[i] <= b_in[i];
                    t_reg[i] <= t_in[i];
                end
            end else if (state_reg == ACCUM) begin
                acc_reg <= acc_next;
                idx_reg <= idx_end[1:0];
                if (last_step) begin
                    product_reg  <= acc_next[15:0];
                    overflow_reg <= acc_next[16];
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Scoreboard bench for ha_array_accumulator at ROWS_PER_CYCLE = 1, 2 and 4.
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  overflow;
    logic [15:0] product [3];
    logic [6:0]  bb [4];
    logic [8:0]  tt [4];

    int checks = 0;
    int errors = 0;
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            ha_array_accumulator #(.ROWS_PER_CYCLE(1 << gi)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .in_valid     (in_valid[gi]),
                .in_ready     (in_ready[gi]),
                .ha_array_0_b (bb[0]),
                .ha_array_0_t (tt[0]),
                .ha_array_1_b (bb[1]),
                .ha_array_1_t (tt[1]),
                .ha_array_2_b (bb[2]),
                .ha_array_2_t (tt[2]),
                .ha_array_3_b (bb[3]),
                .ha_array_3_t (tt[3]),
                .out_valid    (out_valid[gi]),
                .out_ready    (out_ready[gi]),
                .product      (product[gi]),
                .overflow     (overflow[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum over rows of (t + 4b) * 4^k, exact in 17 bits.
    function automatic logic [16:0] model();
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(tt[k]) + 4 * int'(bb[k])) * (4 ** k);
        end
        return 17'(s);
    endfunction

    task automatic set_rows(input logic [6:0] b, input logic [8:0] t);
        for (int k = 0; k < 4; k++) begin
            bb[k] = b;
            tt[k] = t;
        end
    endtask

    task automatic rand_rows();
        for (int k = 0; k < 4; k++) begin
            bb[k] = 7'($urandom);
            tt[k] = 9'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on instance s; returns cycles elapsed (bounded).
    task automatic wait_valid(input int s, output int lat);
        lat = 0;
        while (!out_valid[s] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_compare(input int s, input string tag);
        logic [16:0] e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(tag, {15'b0, overflow[s], product[s]}, {15'b0, e});
            $display("txn R=%0d %s result %05h expected %05h", 1 << s, tag,
                     {overflow[s], product[s]}, e);
        end
    endtask

    // One accept with out_ready low, latency check, result check, then consume.
    task automatic run_one(input int s, input string tag);
        int lat;
        in_valid[s]  = 1'b1;
        out_ready[s] = 1'b0;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready[s]), 32'd1);
        sb.push_back(model());
        tick();
        in_valid[s] = 1'b0;
        rand_rows();
        wait_valid(s, lat);
        check({tag, "_latency"}, 32'(lat), 32'(4 >> s));
        pop_compare(s, tag);
        out_ready[s] = 1'b1;
        tick();
        out_ready[s] = 1'b0;
        check({tag, "_consumed"}, 32'(out_valid[s]), 32'd0);
    endtask

    task automatic run_random(input int s, input int n);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic acc, con;
        in_valid[s] = 1'b0;
        while ((sent < n || got < n) && cyc < 20000) begin
            if (!in_valid[s] && sent < n && $urandom_range(3) != 0) begin
                rand_rows();
                in_valid[s] = 1'b1;
            end
            out_ready[s] = ($urandom_range(3) != 0);
            #1;
            acc = in_valid[s] && in_ready[s];
            con = out_valid[s] && out_ready[s];
            if (con) begin
                pop_compare(s, "rand");
                got++;
            end
            if (acc) begin
                sb.push_back(model());
                sent++;
            end
            tick();
            cyc++;
            if (acc) in_valid[s] = 1'b0;
        end
        in_valid[s]  = 1'b0;
        out_ready[s] = 1'b0;
        check("rand_count", 32'(got), 32'(n));
        check("rand_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] held;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        set_rows(7'h00, 9'h000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_in_ready", 32'(in_ready[s]), 32'd1);
            check("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check("rst_product", 32'(product[s]), 32'd0);
            check("rst_overflow", 32'(overflow[s]), 32'd0);
        end
        tick();

        // Directed values, R=1
        set_rows(7'h00, 9'h000);
        run_one(0, "zero");
        set_rows(7'h00, 9'h000);
        tt[0] = 9'h001;
        run_one(0, "t0_one");
        set_rows(7'h00, 9'h000);
        bb[3] = 7'h7F;
        tt[3] = 9'h1FF;
        run_one(0, "row3_max");
        for (int s = 0; s < 3; s++) begin
            set_rows(7'h7F, 9'h1FF);
            run_one(s, "all_max");
        end

        // Backpressure with same-cycle handoff, R=1
        rand_rows();
        in_valid[0] = 1'b1;
        #1;
        sb.push_back(model());
        tick();
        in_valid[0] = 1'b0;
        wait_valid(0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        held = product[0];
        for (int i = 0; i < 10; i++) begin
            rand_rows();
            in_valid[0] = 1'b1;
            #1;
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
            check("bp_product_hold", 32'(product[0]), 32'(held));
            tick();
        end
        out_ready[0] = 1'b1;
        #1;
        check("bp_handoff_ready", 32'(in_ready[0]), 32'd1);
        pop_compare(0, "bp_first");
        sb.push_back(model());
        tick();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        rand_rows();
        wait_valid(0, lat);
        check("bp_next_latency", 32'(lat), 32'd4);
        pop_compare(0, "bp_second");
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Reset two cycles into ACCUM discards the result
        set_rows(7'h7F, 9'h1FF);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_product", 32'(product[0]), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        tick();
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_stale", 32'(out_valid[0]), 32'd0);
        end
        out_ready[0] = 1'b0;

        // Random traffic with stalls on every configuration
        for (int s = 0; s < 3; s++) begin
            run_random(s, 400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
